sys1_vram_arb: RTL and testbench

Time-slot arbiter that shares one single-port synchronous video RAM between the video fetch pipeline and the Z80 CPU. It sits between the HV timing generator, the tile/sprite fetchers and the VRAM macro. Video fetches get a guaranteed slot on every pixel-clock enable, and the CPU gets every remaining cycle through a wait-state handshake. The block keeps fetch latency fixed so the fetchers' pixel pipeline stays aligned to HPOS.

---
 rtl/sys1_vram_arb.sv | 137 +++++++++++++
 tb/tb_sys1_vram_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys1_vram_arb.sv
// Time-slot arbiter sharing one synchronous single-port VRAM between video fetch and the Z80 CPU.
// Latency: video data strobes 3 cycles after the request; an uncontended CPU access releases WAIT 3 cycles after grant.
// Backpressure: video is never stalled; the CPU is held with combinational CPU_WAIT while video owns the slot or its access is in flight.
module sys1_vram_arb #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PCLK_EN,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_AD,
    output logic [DW-1:0] VID_DT,
    output logic          VID_VLD,
    input  logic          CPU_RD,
    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_AD,
    input  logic [DW-1:0] CPU_DI,
    output logic [DW-1:0] CPU_DO,
    output logic          CPU_WAIT,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    // Owner of the RAM slot issued in a given cycle; travels with the read data.
    typedef enum logic [1:0] {
        T_NONE   = 2'd0,
        T_VID    = 2'd1,
        T_CPU_RD = 2'd2,
        T_CPU_WR = 2'd3
    } tag_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_ISSUE = 2'd1,
        C_LATCH = 2'd2,
        C_DONE  = 2'd3
    } cpu_state_t;

    // Next RAM command, registered onto the RAM pins at the end of the slot.
    typedef struct packed {
        logic [AW-1:0] ad;
        logic          we;
        logic [DW-1:0] di;
    } ram_cmd_t;

    cpu_state_t state;
    tag_t       tag_s1;
    tag_t       tag_s2;
    tag_t       tag_new;
    ram_cmd_t   cmd_nxt;
    logic       vid_grant;
    logic       cpu_req;
    logic       cpu_grant;

    // Slot decision: video owns every pixel-enable slot it asks for, the CPU takes the rest.
    always_comb begin
        vid_grant = PCLK_EN & VID_REQ;
        cpu_req   = CPU_RD | CPU_WR;
        cpu_grant = ~vid_grant & cpu_req & (state == C_IDLE);
        tag_new   = T_NONE;
        cmd_nxt   = '{ad: RAM_AD, we: 1'b0, di: RAM_DI};
        if (vid_grant) begin
            tag_new    = T_VID;
            cmd_nxt.ad = VID_AD;
        end else if (cpu_grant) begin
            // Simultaneous RD and WR resolves to a write.
            tag_new    = CPU_WR ? T_CPU_WR : T_CPU_RD;
            cmd_nxt.ad = CPU_AD;
            cmd_nxt.we = CPU_WR;
            cmd_nxt.di = CPU_DI;
        end
    end

    // WAIT must be combinational so the CPU sees it within the same T-state.
    assign CPU_WAIT = cpu_req & (state != C_DONE);

    // Register the chosen command onto the RAM port; idle slots keep the address and drop WE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RAM_AD <= '0;
            RAM_WE <= 1'b0;
            RAM_DI <= '0;
        end else begin
            RAM_AD <= cmd_nxt.ad;
            RAM_WE <= cmd_nxt.we;
            RAM_DI <= cmd_nxt.di;
        end
    end

    // Two-stage owner pipe lines the tag up with RAM_DO two cycles after issue.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tag_s1 <= T_NONE;
            tag_s2 <= T_NONE;
        end else begin
            tag_s1 <= tag_new;
            tag_s2 <= tag_s1;
        end
    end

    // Steer returning read data to its owner; VID_VLD is a single-cycle strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VID_DT  <= '0;
            VID_VLD <= 1'b0;
            CPU_DO  <= '0;
        end else begin
            VID_VLD <= (tag_s2 == T_VID);
            if (tag_s2 == T_VID) begin
                VID_DT <= RAM_DO;
            end
            if (tag_s2 == T_CPU_RD) begin
                CPU_DO <= RAM_DO;
            end
        end
    end

    // CPU access sequencer: once granted the access always runs to completion,
    // and it parks in C_DONE until the CPU drops its request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= C_IDLE;
        end else begin
            case (state)
                C_IDLE:  if (cpu_grant) state <= C_ISSUE;
                C_ISSUE: state <= C_LATCH;
                C_LATCH: state <= C_DONE;
                C_DONE:  if (!cpu_req) state <= C_IDLE;
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys1_vram_arb.sv
// Self-checking bench for sys1_vram_arb with a behavioural synchronous VRAM.
// Video strobes are checked continuously by a monitor; CPU accesses via vectors, hand sequences and random traffic.
// The random CPU reference predicts release time from the slot rule: first non-video cycle plus three.
module tb_sys1_vram_arb;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NR = 3000;

    logic          CLK;
    logic          RESET;
    logic          PCLK_EN;
    logic          VID_REQ;
    logic [AW-1:0] VID_AD;
    logic [DW-1:0] VID_DT;
    logic          VID_VLD;
    logic          CPU_RD;
    logic          CPU_WR;
    logic [AW-1:0] CPU_AD;
    logic [DW-1:0] CPU_DI;
    logic [DW-1:0] CPU_DO;
    logic          CPU_WAIT;
    logic [AW-1:0] RAM_AD;
    logic          RAM_WE;
    logic [DW-1:0] RAM_DI;
    logic [DW-1:0] RAM_DO;

    sys1_vram_arb #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .VID_REQ(VID_REQ), .VID_AD(VID_AD),
        .VID_DT(VID_DT), .VID_VLD(VID_VLD), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_AD(CPU_AD),
        .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_WAIT(CPU_WAIT), .RAM_AD(RAM_AD), .RAM_WE(RAM_WE),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    int          errors = 0;
    int          checks = 0;
    int          we_total = 0;
    int          vld_total = 0;
    logic [13:0] last_we_ad = '0;
    logic [7:0]  last_we_di = '0;
    bit          mon_en = 0;

    logic [7:0]  mem [0:16383];
    bit          vh_req [0:3];
    logic [13:0] vh_ad  [0:3];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single-port synchronous RAM, preloaded with data = addr[7:0].
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        RAM_DO = '0;
        forever begin
            @(posedge CLK);
            if (RAM_WE) mem[RAM_AD] <= RAM_DI;
            RAM_DO <= mem[RAM_AD];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Video monitor: a request in cycle c must strobe in cycle c+3 with data = addr[7:0].
    always @(negedge CLK) begin
        for (int i = 3; i > 0; i--) begin
            vh_req[i] = vh_req[i-1];
            vh_ad[i]  = vh_ad[i-1];
        end
        vh_req[0] = PCLK_EN & VID_REQ & !RESET;
        vh_ad[0]  = VID_AD;
        if (RESET) for (int i = 0; i < 4; i++) vh_req[i] = 1'b0;
        if (RAM_WE) begin
            we_total++;
            last_we_ad = RAM_AD;
            last_we_di = RAM_DI;
        end
        if (VID_VLD) vld_total++;
        if (mon_en) begin
            check("vid_vld", 32'(VID_VLD), 32'(vh_req[3]));
            if (vh_req[3]) check("vid_dt", 32'(VID_DT), 32'(vh_ad[3][7:0]));
        end
    end

    // One CPU access from idle, optionally colliding with a video slot in its first cycle.
    task automatic run_op(input bit wr, input logic [13:0] ad, input logic [7:0] di, input bit collide,
                          output int nwait, output int nwe, output logic [7:0] dout);
        int we0;
        we0 = we_total;
        tick();
        CPU_RD = !wr; CPU_WR = wr; CPU_AD = ad; CPU_DI = di;
        PCLK_EN = collide; VID_REQ = collide; VID_AD = 14'h0180;
        nwait = 0;
        @(negedge CLK);
        while (CPU_WAIT && nwait < 20) begin
            nwait++;
            tick();
            PCLK_EN = 1'b0; VID_REQ = 1'b0;
            @(negedge CLK);
        end
        dout = CPU_DO;
        tick();
        CPU_RD = 1'b0; CPU_WR = 1'b0; PCLK_EN = 1'b0; VID_REQ = 1'b0;
        tick();
        @(negedge CLK);
        nwe = we_total - we0;
    endtask

    typedef struct {
        bit          wr;
        logic [13:0] ad;
        logic [7:0]  di;
        bit          collide;
        int          exp_wait;
        logic [7:0]  exp_do;
        int          exp_we;
    } vec_t;

    vec_t        vt [0:7];
    bit          pe [0:NR+3];
    bit          vr [0:NR+3];
    logic [13:0] va [0:NR+3];
    logic [7:0]  cpu_mem [0:255];

    initial begin
        int          nw, ne, w0, v0, nreq, cs, g, exp_done, r_off;
        bit          done, r_wr;
        logic [7:0]  d;

        vt[0] = '{1'b1, 14'h1234, 8'h5A, 1'b0, 3, 8'h00, 1};
        vt[1] = '{1'b0, 14'h1234, 8'h00, 1'b0, 3, 8'h5A, 0};
        vt[2] = '{1'b0, 14'h0042, 8'h00, 1'b1, 4, 8'h42, 0};
        vt[3] = '{1'b1, 14'h3FFF, 8'hA5, 1'b1, 4, 8'h00, 1};
        vt[4] = '{1'b0, 14'h3FFF, 8'h00, 1'b0, 3, 8'hA5, 0};
        vt[5] = '{1'b0, 14'h1234, 8'h00, 1'b1, 4, 8'h5A, 0};
        vt[6] = '{1'b1, 14'h0300, 8'hFF, 1'b0, 3, 8'h00, 1};
        vt[7] = '{1'b0, 14'h0300, 8'h00, 1'b0, 3, 8'hFF, 0};

        RESET = 1'b1; PCLK_EN = 1'b0; VID_REQ = 1'b0; VID_AD = '0;
        CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_AD = '0; CPU_DI = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ram_ad", 32'(RAM_AD), 0);
        check("rst_ram_we", 32'(RAM_WE), 0);
        check("rst_ram_di", 32'(RAM_DI), 0);
        check("rst_vid_dt", 32'(VID_DT), 0);
        check("rst_vid_vld", 32'(VID_VLD), 0);
        check("rst_cpu_do", 32'(CPU_DO), 0);
        check("rst_wait_idle", 32'(CPU_WAIT), 0);
        CPU_RD = 1'b1;
        #1;
        check("rst_wait_req", 32'(CPU_WAIT), 1);
        tick();
        RESET = 1'b0; CPU_RD = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Table of single CPU accesses
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].wr, vt[i].ad, vt[i].di, vt[i].collide, nw, ne, d);
            check($sformatf("vec%0d_wait", i), nw, vt[i].exp_wait);
            check($sformatf("vec%0d_we", i), ne, vt[i].exp_we);
            if (vt[i].wr) begin
                check($sformatf("vec%0d_we_ad", i), 32'(last_we_ad), 32'(vt[i].ad));
                check($sformatf("vec%0d_we_di", i), 32'(last_we_di), 32'(vt[i].di));
            end else begin
                check($sformatf("vec%0d_do", i), 32'(d), 32'(vt[i].exp_do));
            end
        end

        // Video only, every 4th cycle, no writes
        v0 = vld_total; w0 = we_total;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                PCLK_EN = (j == 0); VID_REQ = 1'b1; VID_AD = 14'h0100 + 14'(k);
            end
        end
        tick();
        PCLK_EN = 1'b0; VID_REQ = 1'b0;
        repeat (4) tick();
        @(negedge CLK);
        check("vid4_count", vld_total - v0, 8);
        check("vid4_no_we", we_total - w0, 0);

        // Back-to-back video with a CPU read of 0x0000 colliding on a video slot
        v0 = vld_total; nreq = 0; nw = 0; done = 1'b0; d = '0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done) CPU_RD = 1'b0;
            PCLK_EN = (j % 2 == 0); VID_REQ = 1'b1; VID_AD = 14'(j);
            if (j % 2 == 0) nreq++;
            if (j == 4) begin CPU_RD = 1'b1; CPU_AD = 14'h0000; end
            @(negedge CLK);
            if (CPU_RD && !done) begin
                if (CPU_WAIT) nw++;
                else begin done = 1'b1; d = CPU_DO; end
            end
        end
        tick();
        CPU_RD = 1'b0; PCLK_EN = 1'b0; VID_REQ = 1'b0;
        repeat (4) tick();
        @(negedge CLK);
        check("b2b_cpu_done", 32'(done), 1);
        check("b2b_cpu_wait", nw, 4);
        check("b2b_cpu_do", 32'(d), 0);
        check("b2b_vid_count", vld_total - v0, nreq);

        // Write dropped while in ISSUE still lands; next access accepted normally
        w0 = we_total;
        tick();
        CPU_WR = 1'b1; CPU_AD = 14'h0400; CPU_DI = 8'h77;
        tick();
        CPU_WR = 1'b0;
        @(negedge CLK);
        check("drop_ram_we", 32'(RAM_WE), 1);
        check("drop_wait", 32'(CPU_WAIT), 0);
        tick();
        tick();
        run_op(1'b0, 14'h0400, 8'h00, 1'b0, nw, ne, d);
        check("drop_next_wait", nw, 3);
        check("drop_next_do", 32'(d), 32'h77);
        check("drop_we_count", we_total - w0, 1);

        // Reset pulsed in ISSUE of a write to 0x0200: aborted, then re-executed once
        w0 = we_total;
        tick();
        CPU_WR = 1'b1; CPU_AD = 14'h0200; CPU_DI = 8'hC3;
        tick();
        RESET = 1'b1;
        @(negedge CLK);
        check("rstw_ram_ad", 32'(RAM_AD), 0);
        check("rstw_ram_we", 32'(RAM_WE), 0);
        check("rstw_ram_di", 32'(RAM_DI), 0);
        check("rstw_vid_dt", 32'(VID_DT), 0);
        check("rstw_cpu_do", 32'(CPU_DO), 0);
        check("rstw_wait", 32'(CPU_WAIT), 1);
        tick();
        RESET = 1'b0;
        nw = 0;
        @(negedge CLK);
        while (CPU_WAIT && nw < 20) begin
            nw++;
            tick();
            @(negedge CLK);
        end
        tick();
        CPU_WR = 1'b0;
        tick();
        @(negedge CLK);
        check("rstw_rewait", nw, 3);
        check("rstw_we_count", we_total - w0, 1);
        check("rstw_we_ad", 32'(last_we_ad), 32'h0200);
        check("rstw_we_di", 32'(last_we_di), 32'hC3);
        run_op(1'b0, 14'h0200, 8'h00, 1'b0, nw, ne, d);
        check("rstw_readback", 32'(d), 32'hC3);

        // Random video slots (never two in a row) with random CPU traffic
        for (int k = 0; k < NR + 4; k++) begin
            if (k >= NR) pe[k] = 1'b0;
            else if (k == 0) pe[k] = 1'($urandom_range(0, 1));
            else pe[k] = !pe[k-1] && 1'($urandom_range(0, 1));
            vr[k] = ($urandom_range(0, 3) != 0);
            va[k] = 14'($urandom_range(0, 511));
        end
        for (int i = 0; i < 256; i++) cpu_mem[i] = 8'(i);
        cs = 0; exp_done = 0; r_off = 0; r_wr = 1'b0;
        for (int c = 0; c < NR; c++) begin
            tick();
            PCLK_EN = pe[c]; VID_REQ = vr[c]; VID_AD = va[c];
            if (cs == 2) begin
                CPU_RD = 1'b0; CPU_WR = 1'b0; cs = 0;
            end else if (cs == 0 && c < NR - 8 && $urandom_range(0, 2) == 0) begin
                r_wr   = 1'($urandom_range(0, 1));
                r_off  = int'($urandom_range(0, 255));
                CPU_AD = 14'h2000 + 14'(r_off);
                CPU_DI = 8'($urandom);
                CPU_WR = r_wr;
                CPU_RD = !r_wr || ($urandom_range(0, 3) == 0);
                if (r_wr) cpu_mem[r_off] = CPU_DI;
                g = c;
                while (pe[g] && vr[g]) g++;
                exp_done = g + 3;
                cs = 1;
            end
            @(negedge CLK);
            if (cs == 1) begin
                check("rnd_wait", 32'(CPU_WAIT), 32'(c < exp_done));
                if (c == exp_done) begin
                    if (!r_wr) check("rnd_do", 32'(CPU_DO), 32'(cpu_mem[r_off]));
                    cs = 2;
                end
            end
        end
        tick();
        CPU_RD = 1'b0; CPU_WR = 1'b0; PCLK_EN = 1'b0; VID_REQ = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        for (int i = 0; i < 256; i++) check("rnd_mem", 32'(mem[16'h2000 + i]), 32'(cpu_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
